// File: rtl/axis_packet_arbiter_pkg.sv
// rtl/axis_packet_arbiter_pkg.sv - shared types and width helper for the packet arbiter
package axis_packet_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PASS,
    ST_DISCARD
  } state_t;

  // Word counter must hold 0..max_words-1 with headroom for the compare constant.
  function automatic int count_width(input int max_words);
    return $clog2(max_words + 1);
  endfunction

endpackage

// File: rtl/axis_packet_arbiter_rr_select.sv
// rtl/axis_packet_arbiter_rr_select.sv - combinational round-robin picker
module axis_packet_arbiter_rr_select
  import axis_packet_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_idx,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  // Search starts just after the previous winner so every source gets a turn.
  always_comb begin
    logic found;
    int   cand;
    valid = |req;
    idx   = last_idx;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(last_idx) + i) % NUM_REQ;
      if (!found && req[cand]) begin
        idx   = IDX_W'(cand);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_packet_arbiter.sv
// rtl/axis_packet_arbiter.sv - packet-granular round-robin arbiter feeding one packet FIFO
module axis_packet_arbiter
  import axis_packet_arbiter_pkg::*;
#(
  parameter int NUM_SRC        = 4,
  parameter int AXIS_BYTES     = 2,
  parameter int AXIS_USER_BITS = 1,
  parameter int MAX_PKT_WORDS  = 1024
) (
  input  logic                                 i_clk,
  input  logic                                 i_areset,
  output logic [NUM_SRC-1:0]                   axis_i_tready,
  input  logic [NUM_SRC-1:0]                   axis_i_tvalid,
  input  logic [NUM_SRC-1:0]                   axis_i_tlast,
  input  logic [NUM_SRC*AXIS_BYTES*8-1:0]      axis_i_tdata,
  input  logic [NUM_SRC*AXIS_USER_BITS-1:0]    axis_i_tuser,
  input  logic [NUM_SRC-1:0]                   axis_i_drop,
  input  logic                                 axis_o_tready,
  output logic                                 axis_o_tvalid,
  output logic                                 axis_o_tlast,
  output logic [AXIS_BYTES*8-1:0]              axis_o_tdata,
  output logic [AXIS_USER_BITS-1:0]            axis_o_tuser,
  output logic                                 axis_o_drop,
  output logic [$clog2(NUM_SRC)-1:0]           o_grant,
  output logic                                 o_busy,
  output logic                                 o_overlength
);

  localparam int GW = $clog2(NUM_SRC);
  localparam int DW = AXIS_BYTES * 8;
  localparam int CW = count_width(MAX_PKT_WORDS);

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovl_q, ovl_d;

  logic            sel_valid;
  logic [GW-1:0]   sel_idx;

  logic                      g_tvalid, g_tlast, g_drop;
  logic [DW-1:0]             g_tdata;
  logic [AXIS_USER_BITS-1:0] g_tuser;

  axis_packet_arbiter_rr_select #(
    .NUM_REQ (NUM_SRC),
    .IDX_W   (GW)
  ) u_rr_select (
    .req      (axis_i_tvalid),
    .last_idx (grant_q),
    .valid    (sel_valid),
    .idx      (sel_idx)
  );

  assign g_tvalid = axis_i_tvalid[grant_q];
  assign g_tlast  = axis_i_tlast[grant_q];
  assign g_drop   = axis_i_drop[grant_q];
  assign g_tdata  = axis_i_tdata[grant_q*DW +: DW];
  assign g_tuser  = axis_i_tuser[grant_q*AXIS_USER_BITS +: AXIS_USER_BITS];

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    cnt_d         = cnt_q;
    ovl_d         = 1'b0;
    axis_i_tready = '0;
    axis_o_tvalid = 1'b0;
    axis_o_tlast  = g_tlast;
    axis_o_tdata  = g_tdata;
    axis_o_tuser  = g_tuser;
    axis_o_drop   = g_drop;
    unique case (state_q)
      ST_IDLE: begin
        if (sel_valid) begin
          grant_d = sel_idx;
          state_d = ST_PASS;
        end
      end
      ST_PASS: begin
        axis_i_tready[grant_q] = axis_o_tready;
        axis_o_tvalid          = g_tvalid;
        if (g_tvalid && axis_o_tready) begin
          // tlast wins over the length kill so a maximum-length packet survives.
          if (g_tlast) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else if (g_drop) begin
            cnt_d   = '0;
            state_d = ST_DISCARD;
          end else if (cnt_q == CW'(MAX_PKT_WORDS - 1)) begin
            axis_o_drop = 1'b1;
            ovl_d       = 1'b1;
            cnt_d       = '0;
            state_d     = ST_DISCARD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_DISCARD: begin
        axis_i_tready[grant_q] = 1'b1;
        if (g_tvalid && g_tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      state_q <= ST_IDLE;
      grant_q <= GW'(NUM_SRC - 1);
      cnt_q   <= '0;
      ovl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      ovl_q   <= ovl_d;
    end
  end

  assign o_grant      = grant_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_overlength = ovl_q;

endmodule
